// File: rtl/perf_event_counters_if.sv
// Decode-side bus for perf_event_counters: event inputs, control, read port and overflow status.
// master drives the inputs and observes results; slave is the counter block.
interface perf_event_counters_if #(
   parameter int unsigned CNT_W = 32
);
   logic [31:0]      i_instr;
   logic             i_slot_en;
   logic             i_freeze;
   logic             i_clr;
   logic [2:0]       i_rd_idx;
   logic [7:0]       i_ovf_mask;
   logic [CNT_W-1:0] o_rd_data;
   logic [7:0]       o_ovf;
   logic             o_ovf_irq;

   modport master (
      output i_instr, i_slot_en, i_freeze, i_clr, i_rd_idx, i_ovf_mask,
      input  o_rd_data, o_ovf, o_ovf_irq
   );

   modport slave (
      input  i_instr, i_slot_en, i_freeze, i_clr, i_rd_idx, i_ovf_mask,
      output o_rd_data, o_ovf, o_ovf_irq
   );
endinterface

// File: rtl/perf_event_counters.sv
// Eight decode-stage event counters with registered read port, clear, freeze, wrap/saturate and sticky overflow.
// Optional overflow interrupt enabled by defining PERF_OVF_IRQ_EN.
module perf_event_counters #(
   parameter int unsigned CNT_W    = 32,
   parameter bit          SAT_MODE = 1'b0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   perf_event_counters_if.slave  pec_bus
);

   localparam int unsigned NUM_CNT = 8;
   localparam int unsigned IDX_W   = 3;
   localparam int unsigned OPC_W   = 7;

   localparam logic [IDX_W-1:0] IDX_CYCLE   = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_RETIRED = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_INVALID = IDX_W'(2);
   localparam logic [IDX_W-1:0] IDX_LOAD    = IDX_W'(3);
   localparam logic [IDX_W-1:0] IDX_STORE   = IDX_W'(4);
   localparam logic [IDX_W-1:0] IDX_BRANCH  = IDX_W'(5);
   localparam logic [IDX_W-1:0] IDX_JUMP    = IDX_W'(6);
   localparam logic [IDX_W-1:0] IDX_ALU     = IDX_W'(7);

   localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
   localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [OPC_W-1:0]   opcode_c;
   logic               known_opc_c;
   logic [IDX_W-1:0]   cls_idx_c;
   logic               valid_c;
   logic [NUM_CNT-1:0] inc_c;

   logic [CNT_W-1:0]   cnt_q [NUM_CNT];
   logic [CNT_W-1:0]   cnt_d [NUM_CNT];
   logic [NUM_CNT-1:0] ovf_q;
   logic [NUM_CNT-1:0] ovf_d;
   logic [CNT_W-1:0]   rd_data_q;
   logic [CNT_W-1:0]   rd_data_d;

   assign opcode_c = pec_bus.i_instr[OPC_W-1:0];

   // Opcode classification; an all-zero word is a bubble even though its opcode is decodable as nothing.
   always_comb begin
      known_opc_c = 1'b1;
      cls_idx_c   = IDX_ALU;
      unique case (opcode_c)
         OPC_LOAD:                               cls_idx_c = IDX_LOAD;
         OPC_STORE:                              cls_idx_c = IDX_STORE;
         OPC_BRANCH:                             cls_idx_c = IDX_BRANCH;
         OPC_JAL, OPC_JALR:                      cls_idx_c = IDX_JUMP;
         OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC:  cls_idx_c = IDX_ALU;
         default:                                known_opc_c = 1'b0;
      endcase
   end

   assign valid_c = known_opc_c && (pec_bus.i_instr != 32'h0000_0000);

   // Per-counter event strobes for this cycle, before freeze/clear gating.
   always_comb begin
      inc_c            = '0;
      inc_c[IDX_CYCLE] = 1'b1;
      if (pec_bus.i_slot_en) begin
         if (valid_c) begin
            inc_c[IDX_RETIRED] = 1'b1;
            inc_c[cls_idx_c]   = 1'b1;
         end else begin
            inc_c[IDX_INVALID] = 1'b1;
         end
      end
   end

   // Counter and overflow next-state: clear beats freeze beats increment.
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (pec_bus.i_clr) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = '0;
         end
         ovf_d = '0;
      end else if (!pec_bus.i_freeze) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            if (inc_c[i]) begin
               if (cnt_q[i] == CNT_MAX) begin
                  ovf_d[i] = 1'b1;
                  cnt_d[i] = SAT_MODE ? CNT_MAX : '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
         end
      end
   end

   // Read port samples the pre-update value, so a read in the clear cycle shows the old count.
   assign rd_data_d = cnt_q[pec_bus.i_rd_idx];

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            cnt_q[i] <= '0;
         end
         ovf_q     <= '0;
         rd_data_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CNT; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         ovf_q     <= ovf_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign pec_bus.o_rd_data = rd_data_q;
   assign pec_bus.o_ovf     = ovf_q;

`ifdef PERF_OVF_IRQ_EN
   logic ovf_irq_q;
   logic ovf_irq_d;

   // Built from next-state flags so the interrupt rises on the same edge as the flag.
   assign ovf_irq_d = |(ovf_d & pec_bus.i_ovf_mask);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         ovf_irq_q <= 1'b0;
      end else begin
         ovf_irq_q <= ovf_irq_d;
      end
   end

   assign pec_bus.o_ovf_irq = ovf_irq_q;
`else
   logic unused_ovf_mask;

   assign unused_ovf_mask   = ^pec_bus.i_ovf_mask;
   assign pec_bus.o_ovf_irq = 1'b0;
`endif

endmodule

// File: tb/tb_perf_event_counters.sv
// Directed bench for perf_event_counters: a 32-bit wrap instance plus 4-bit wrap and saturate instances.
module tb_perf_event_counters;

   logic        clk;
   logic        rst_a;
   logic        rst_bc;
   logic [31:0] instr;
   logic        slot_en;
   logic        freeze;
   logic        clr;
   logic [2:0]  rd_idx;
   logic [7:0]  ovf_mask;

   int n_total;
   int n_bad;

   perf_event_counters_if #(.CNT_W(32)) if_a ();
   perf_event_counters_if #(.CNT_W(4))  if_b ();
   perf_event_counters_if #(.CNT_W(4))  if_c ();

   assign if_a.i_instr = instr;   assign if_b.i_instr = instr;   assign if_c.i_instr = instr;
   assign if_a.i_slot_en = slot_en; assign if_b.i_slot_en = slot_en; assign if_c.i_slot_en = slot_en;
   assign if_a.i_freeze = freeze; assign if_b.i_freeze = freeze; assign if_c.i_freeze = freeze;
   assign if_a.i_clr = clr;       assign if_b.i_clr = clr;       assign if_c.i_clr = clr;
   assign if_a.i_rd_idx = rd_idx; assign if_b.i_rd_idx = rd_idx; assign if_c.i_rd_idx = rd_idx;
   assign if_a.i_ovf_mask = ovf_mask; assign if_b.i_ovf_mask = ovf_mask; assign if_c.i_ovf_mask = ovf_mask;

   perf_event_counters #(.CNT_W(32), .SAT_MODE(1'b0)) u_dut_a (.i_clk(clk), .i_rst(rst_a),  .pec_bus(if_a.slave));
   perf_event_counters #(.CNT_W(4),  .SAT_MODE(1'b0)) u_dut_b (.i_clk(clk), .i_rst(rst_bc), .pec_bus(if_b.slave));
   perf_event_counters #(.CNT_W(4),  .SAT_MODE(1'b1)) u_dut_c (.i_clk(clk), .i_rst(rst_bc), .pec_bus(if_c.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Frozen one-cycle read of instance A; counters do not move while reading.
   task automatic rd_a(input logic [2:0] idx, input logic [63:0] exp);
      freeze = 1'b1;
      rd_idx = idx;
      tick();
      chk($sformatf("a_idx%0d", idx), 64'(if_a.o_rd_data), exp);
   endtask

   logic [31:0] words1 [6];
   logic [31:0] words2 [6];
   logic [63:0] exp1   [8];
   logic [63:0] exp2   [8];
   logic [2:0]  fz_idx [4];
   logic [63:0] fz_exp [4];

   initial begin
      n_total  = 0;
      n_bad    = 0;
      words1   = '{32'h0000_2083, 32'h0011_2023, 32'h0000_0063, 32'h0000_006F, 32'h0000_0033, 32'h0000_0000};
      words2   = '{32'h0000_8067, 32'h0000_00B7, 32'h0000_0097, 32'h0000_0013, 32'h0000_007F, 32'hFFFF_FFFF};
      exp1     = '{64'd6, 64'd5, 64'd1, 64'd1, 64'd1, 64'd1, 64'd1, 64'd1};
      exp2     = '{64'd15, 64'd9, 64'd3, 64'd1, 64'd1, 64'd1, 64'd2, 64'd4};
      fz_idx   = '{3'd0, 3'd1, 3'd2, 3'd7};
      fz_exp   = '{64'd9, 64'd5, 64'd1, 64'd1};

      rst_a    = 1'b0;
      rst_bc   = 1'b0;
      instr    = 32'h0000_0013;
      slot_en  = 1'b1;
      freeze   = 1'b0;
      clr      = 1'b0;
      rd_idx   = 3'd0;
      ovf_mask = 8'h01;

      // Reset held two cycles with live valid slots.
      tick();
      tick();
      chk("rst_rd", 64'(if_a.o_rd_data), 64'd0);
      chk("rst_ovf", 64'(if_a.o_ovf), 64'd0);
      chk("rst_irq", 64'(if_a.o_ovf_irq), 64'd0);

      rst_a = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      rd_a(3'd0, 64'd5);
      rd_a(3'd1, 64'd5);
      rd_a(3'd7, 64'd5);
      rd_a(3'd2, 64'd0);

      clr = 1'b1;
      tick();
      clr = 1'b0;

      // One of each class plus a zero word.
      freeze  = 1'b0;
      slot_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         instr = words1[i];
         tick();
      end
      for (int i = 0; i < 8; i++) rd_a(3'(i), exp1[i]);

      // Stalled slots only advance the cycle counter.
      freeze  = 1'b0;
      slot_en = 1'b0;
      instr   = 32'h0000_2083;
      for (int i = 0; i < 3; i++) tick();
      rd_a(3'd0, 64'd9);
      rd_a(3'd1, 64'd5);
      rd_a(3'd3, 64'd1);

      freeze  = 1'b1;
      slot_en = 1'b1;
      instr   = 32'h0000_0033;
      for (int i = 0; i < 4; i++) begin
         rd_idx = fz_idx[i];
         tick();
         chk($sformatf("freeze_idx%0d", fz_idx[i]), 64'(if_a.o_rd_data), fz_exp[i]);
      end

      // jalr, lui, auipc, addi, unknown opcode, all-ones word.
      freeze = 1'b0;
      for (int i = 0; i < 6; i++) begin
         instr = words2[i];
         tick();
      end
      for (int i = 0; i < 8; i++) rd_a(3'(i), exp2[i]);
      chk("a_ovf_none", 64'(if_a.o_ovf), 64'd0);
      chk("a_irq_none", 64'(if_a.o_ovf_irq), 64'd0);

      // Clear wins over freeze and a valid slot; the read in that cycle is pre-clear.
      freeze  = 1'b1;
      slot_en = 1'b1;
      instr   = 32'h0000_2083;
      clr     = 1'b1;
      rd_idx  = 3'd0;
      tick();
      chk("clr_pre", 64'(if_a.o_rd_data), 64'd15);
      clr = 1'b0;
      tick();
      chk("clr_post", 64'(if_a.o_rd_data), 64'd0);
      chk("clr_ovf", 64'(if_a.o_ovf), 64'd0);
      rd_a(3'd1, 64'd0);
      rd_a(3'd7, 64'd0);

      // Narrow instances: only the cycle counter runs.
      rst_bc  = 1'b1;
      freeze  = 1'b0;
      slot_en = 1'b0;
      rd_idx  = 3'd0;
      for (int i = 0; i < 16; i++) tick();
      freeze = 1'b1;
      tick();
      chk("wrap16_rd", 64'(if_b.o_rd_data), 64'd0);
      chk("wrap16_ovf", 64'(if_b.o_ovf), 64'h01);
      chk("sat16_rd", 64'(if_c.o_rd_data), 64'd15);
      chk("sat16_ovf", 64'(if_c.o_ovf), 64'h01);

      freeze = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      freeze = 1'b1;
      tick();
      chk("wrap21_rd", 64'(if_b.o_rd_data), 64'd5);
      chk("wrap21_ovf", 64'(if_b.o_ovf), 64'h01);
      chk("sat21_rd", 64'(if_c.o_rd_data), 64'd15);
      chk("sat21_ovf", 64'(if_c.o_ovf), 64'h01);

`ifdef PERF_OVF_IRQ_EN
      chk("irq_set", 64'(if_b.o_ovf_irq), 64'd1);
      ovf_mask = 8'h00;
      tick();
      chk("irq_masked", 64'(if_b.o_ovf_irq), 64'd0);
      ovf_mask = 8'h01;
      tick();
      chk("irq_unmasked", 64'(if_b.o_ovf_irq), 64'd1);
`else
      chk("irq_tied", 64'(if_b.o_ovf_irq), 64'd0);
`endif

      clr = 1'b1;
      tick();
      chk("b_clr_pre", 64'(if_b.o_rd_data), 64'd5);
      clr = 1'b0;
      tick();
      chk("b_clr_post", 64'(if_b.o_rd_data), 64'd0);
      chk("b_clr_ovf", 64'(if_b.o_ovf), 64'd0);
      chk("b_clr_irq", 64'(if_b.o_ovf_irq), 64'd0);
      chk("c_clr_post", 64'(if_c.o_rd_data), 64'd0);
      chk("c_clr_ovf", 64'(if_c.o_ovf), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/perf_event_counters.md
Name: perf_event_counters

Overview:
- Parametrised successor to the controller's two ad-hoc instruction counters.
- Sits beside the decode stage. It classifies each instruction presented at decode and counts cycles, retired-valid instructions, invalid/bubble slots and five instruction classes in independent counters.
- Provides a registered read port, synchronous clear, freeze, configurable wrap/saturate mode and sticky per-counter overflow flags.

Parameters:
- CNT_W, 32, width of every counter (legal range 4..64).
- SAT_MODE, 0, 0 = counters wrap to 0 at max; 1 = counters hold at all-ones.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, synchronous, active-low.
- i_instr  in  32  instruction word at decode.
- i_slot_en  in  1  decode slot advances this cycle (not stalled); qualifies i_instr.
- i_freeze  in  1  hold all counters.
- i_clr  in  1  synchronous clear of all counters and overflow flags.
- i_rd_idx  in  3  counter select for the read port.
- o_rd_data  out  CNT_W  selected counter value, registered.
- o_ovf  out  8  sticky overflow flag per counter.
- i_ovf_mask  in  8  interrupt enable per counter (optional feature only).
- o_ovf_irq  out  1  overflow interrupt (optional feature only).

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-low. While i_rst=0 at a rising edge: all counters, o_ovf, o_rd_data and o_ovf_irq become 0.
- Counter index map:
  - 0 cycles
  - 1 retired (valid)
  - 2 invalid/bubble
  - 3 load (opcode 0000011)
  - 4 store (0100011)
  - 5 branch (1100011)
  - 6 jump (1101111, 1100111)
  - 7 alu (0110011, 0010011, 0110111, 0010111)
- Validity: a word is valid when i_instr != 0 and i_instr[6:0] is one of the nine opcodes above. All other words are invalid.
- Increments per cycle, only when i_freeze=0 and i_clr=0:
  - Counter 0 increments unconditionally.
  - If i_slot_en=1 and the word is valid: counter 1 and exactly one class counter (3..7) increment.
  - If i_slot_en=1 and the word is invalid: counter 2 increments.
  - If i_slot_en=0: only counter 0 changes.
- Increment rule: +1 modulo 2^CNT_W.
  - SAT_MODE=0: all-ones -> 0, and that counter's o_ovf bit sets.
  - SAT_MODE=1: all-ones holds at all-ones. The o_ovf bit sets on the attempted increment.
- o_ovf bits are sticky until i_clr or reset. An overflow bit set and a clear in the same cycle: the clear wins.
- Priority, highest first: reset > i_clr > i_freeze > increment.
  - i_clr=1: every counter and o_ovf become 0 next edge, regardless of i_freeze or i_slot_en.
  - i_freeze=1 (no clear): counters and o_ovf hold; events in that cycle are dropped, not deferred.
- Read port: o_rd_data <= counter[i_rd_idx] at each edge, so latency is 1 cycle. The value sampled is the pre-update value of that edge.
  - A read in the i_clr cycle returns the pre-clear value. The next read returns 0.
  - o_rd_data updates during freeze.
- i_rd_idx is fully decoded (8 entries); no out-of-range case exists.
- No combinational path from inputs to any output.

Optional Feature:
- Macro: PERF_OVF_IRQ_EN.
- Defined: o_ovf_irq is registered and equals the OR of (o_ovf & i_ovf_mask), evaluated on next-state values, so it asserts the same edge the flag sets. It deasserts the edge after i_clr, or immediately when the mask bit drops (next edge).
- Undefined: o_ovf_irq is tied 0, i_ovf_mask is ignored, and no irq register is synthesised.

Test Plan:
- Reset and sample: hold i_rst=0 for 2 cycles with i_slot_en=1 and i_instr=0x00000013 -> all o_rd_data reads and o_ovf are 0. Release, run 5 cycles -> idx0=5, idx1=5, idx7=5, idx2=0.
- Classification: present lw 0x00002083, sw 0x00112023, beq 0x00000063, jal 0x0000006F, add 0x00000033, and word 0x00000000, one per cycle with i_slot_en=1 -> idx3=idx4=idx5=idx6=1, idx7=1, idx1=5, idx2=1.
- Stall and freeze:
  - i_slot_en=0 for 3 cycles -> only idx0 advances by 3.
  - Then i_freeze=1 for 4 cycles with valid slots -> all counters unchanged, o_rd_data still tracks i_rd_idx.
- Wrap (CNT_W=4, SAT_MODE=0): 16 cycles from reset -> idx0=0 and o_ovf[0]=1. Five more cycles -> idx0=5, o_ovf[0] still 1.
- Saturate (CNT_W=4, SAT_MODE=1): 20 cycles -> idx0=15 and o_ovf[0]=1.
- Clear priority: i_clr=1 together with i_freeze=1 and a valid slot -> that cycle's read returns the old value, next edge all counters and o_ovf are 0. With PERF_OVF_IRQ_EN and i_ovf_mask=0x01 after the wrap test, o_ovf_irq=1 before the clear and 0 after it.
